hilo_md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the pipeline. It accepts mult/multu/div/divu operations flagged by the decode stage's HiLo control, runs a 32-iteration shift-add or restoring-divide datapath, and writes HI/LO on completion. It serves mfhi/mflo reads and raises a pipeline stall whenever a HI/LO access or a new operation arrives while a computation is in flight.

---
 rtl/hilo_md_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_hilo_md_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_md_sequencer.sv
// HI/LO multiply/divide sequencer: 32-cycle shift-add multiply and restoring divide,
// with mfhi/mflo read port and pipeline stall generation.
module hilo_md_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mfhi_req,
  input  logic        mflo_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result_out,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg, count_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [63:0] acc_reg, acc_next;
  logic [31:0] rem_reg, rem_next;
  logic [31:0] rs_orig_reg, rs_orig_next;
  logic        is_div_reg, is_div_next;
  logic        is_signed_reg, is_signed_next;
  logic        sign_a_reg, sign_a_next;
  logic        sign_b_reg, sign_b_next;
  logic        div0_reg, div0_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        done_reg, done_next;

  logic        op_legal;
  logic        op_signed;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [31:0] addend;
  logic [32:0] mult_sum;
  logic [63:0] mult_step;
  logic [32:0] div_partial;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign op_legal  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = ~op[0];
  assign rs_neg    = op_signed & rs_val[31];
  assign rt_neg    = op_signed & rt_val[31];
  // Negating 0x80000000 yields 0x80000000, which is exactly its unsigned magnitude.
  assign rs_mag    = rs_neg ? (~rs_val + 32'd1) : rs_val;
  assign rt_mag    = rt_neg ? (~rt_val + 32'd1) : rt_val;

  // Shift-add: add the multiplicand into the upper half, then shift the whole accumulator right.
  assign addend    = b_reg[0] ? a_reg : 32'd0;
  assign mult_sum  = {1'b0, acc_reg[63:32]} + {1'b0, addend};
  assign mult_step = {mult_sum, acc_reg[31:1]};

  // Restoring divide: the 33-bit partial remainder brings in the next dividend bit.
  assign div_partial = {rem_reg, a_reg[31]};
  assign div_diff    = div_partial - {1'b0, b_reg};

  assign prod_fix = (is_signed_reg & (sign_a_reg ^ sign_b_reg)) ? (~acc_reg + 64'd1) : acc_reg;
  assign quot_fix = (is_signed_reg & (sign_a_reg ^ sign_b_reg)) ? (~a_reg + 32'd1) : a_reg;
  assign rem_fix  = (is_signed_reg & sign_a_reg) ? (~rem_reg + 32'd1) : rem_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      count_reg     <= 5'd0;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      acc_reg       <= 64'd0;
      rem_reg       <= 32'd0;
      rs_orig_reg   <= 32'd0;
      is_div_reg    <= 1'b0;
      is_signed_reg <= 1'b0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      div0_reg      <= 1'b0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      acc_reg       <= acc_next;
      rem_reg       <= rem_next;
      rs_orig_reg   <= rs_orig_next;
      is_div_reg    <= is_div_next;
      is_signed_reg <= is_signed_next;
      sign_a_reg    <= sign_a_next;
      sign_b_reg    <= sign_b_next;
      div0_reg      <= div0_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    acc_next       = acc_reg;
    rem_next       = rem_reg;
    rs_orig_next   = rs_orig_reg;
    is_div_next    = is_div_reg;
    is_signed_next = is_signed_reg;
    sign_a_next    = sign_a_reg;
    sign_b_next    = sign_b_reg;
    div0_next      = div0_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    done_next      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start && op_legal) begin
          state_next     = S_CALC;
          count_next     = 5'd0;
          a_next         = rs_mag;
          b_next         = rt_mag;
          acc_next       = 64'd0;
          rem_next       = 32'd0;
          rs_orig_next   = rs_val;
          is_div_next    = op[1];
          is_signed_next = op_signed;
          sign_a_next    = rs_neg;
          sign_b_next    = rt_neg;
          div0_next      = op[1] && (rt_val == 32'd0);
        end
      end
      S_CALC: begin
        count_next = count_reg + 5'd1;
        if (is_div_reg) begin
          if (!div_diff[32]) begin
            rem_next = div_diff[31:0];
            a_next   = {a_reg[30:0], 1'b1};
          end else begin
            rem_next = div_partial[31:0];
            a_next   = {a_reg[30:0], 1'b0};
          end
        end else begin
          acc_next = mult_step;
          b_next   = {1'b0, b_reg[31:1]};
        end
        if (count_reg == 5'd31) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = S_IDLE;
        count_next = 5'd0;
        done_next  = 1'b1;
        if (!is_div_reg) begin
          hi_next = prod_fix[63:32];
          lo_next = prod_fix[31:0];
        end else if (div0_reg) begin
          hi_next = rs_orig_reg;
          lo_next = 32'hFFFF_FFFF;
        end else begin
          hi_next = rem_fix;
          lo_next = quot_fix;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign hi         = hi_reg;
  assign lo         = lo_reg;
  assign done       = done_reg;
  assign busy       = (state_reg != S_IDLE);
  assign stall      = busy & (start | mfhi_req | mflo_req);
  assign result_out = mfhi_req ? hi_reg : (mflo_req ? lo_reg : 32'd0);

endmodule

// File: tb/tb_hilo_md_sequencer.sv
// Directed bench for hilo_md_sequencer: arithmetic results, latency, stall/done and reset behaviour.
module tb_hilo_md_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mfhi_req;
  logic        mflo_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result_out;
  logic        busy;
  logic        stall;
  logic        done;

  int n_checks;
  int n_fails;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  hilo_md_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .mfhi_req   (mfhi_req),
    .mflo_req   (mflo_req),
    .hi         (hi),
    .lo         (lo),
    .result_out (result_out),
    .busy       (busy),
    .stall      (stall),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
  endtask

  vec_t vecs[7];
  int   n;
  int   stall_cnt;
  int   guard;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 6'd0;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    mfhi_req = 1'b0;
    mflo_req = 1'b0;
    tick();
    tick();
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{OP_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{OP_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3] = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{OP_DIVU,  32'hFFFF_FFF9,  32'd2,         32'h0000_0001, 32'h7FFF_FFFC};
    vecs[5] = '{OP_DIVU,  32'h1234_5678,  32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[6] = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      check_val($sformatf("v%0d_latency", i), n, 32'd33);
      check_val($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check_val($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check_val($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      tick();
      check_val($sformatf("v%0d_done_off", i), {31'd0, done}, 32'd0);
    end

    // Reads in IDLE: both requests select HI; a simultaneous start sees the old values.
    mfhi_req = 1'b1;
    mflo_req = 1'b1;
    #1;
    check_val("both_req_hi", result_out, 32'h0000_0000);
    mfhi_req = 1'b0;
    #1;
    check_val("mflo_read", result_out, 32'h8000_0000);
    mflo_req = 1'b0;

    // mfhi at T5 during mult with a second start held through the computation.
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    for (int i = 0; i < 4; i++) tick();
    mfhi_req = 1'b1;
    start    = 1'b1;
    op       = OP_MULTU;
    rs_val   = 32'hFFFF_FFFF;
    rt_val   = 32'hFFFF_FFFF;
    #1;
    check_val("stall_t5", {31'd0, stall}, 32'd1);
    stall_cnt = 0;
    guard     = 0;
    while (busy && guard < 60) begin
      if (stall) stall_cnt++;
      tick();
      guard++;
    end
    check_val("stall_cycles", stall_cnt, 32'd29);
    check_val("post_stall", {31'd0, stall}, 32'd0);
    check_val("post_result_hi", result_out, 32'hFFFF_FFFF);
    check_val("post_done", {31'd0, done}, 32'd1);
    tick();
    check_val("b2b_accepted", {31'd0, busy}, 32'd1);
    start    = 1'b0;
    mfhi_req = 1'b0;
    wait_idle(n);
    check_val("b2b_latency", n, 32'd33);
    check_val("b2b_hi", hi, 32'hFFFF_FFFE);
    check_val("b2b_lo", lo, 32'h0000_0001);
    tick();

    // Reset in the middle of a divide after HI was set to 0xAAAA0000.
    issue(OP_DIVU, 32'hAAAA_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check_val("pre_hi", hi, 32'hAAAA_0000);
    tick();
    issue(OP_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_hi", hi, 32'd0);
    check_val("abort_lo", lo, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("abort_done2", {31'd0, done}, 32'd0);

    // Illegal op in IDLE is ignored.
    start = 1'b1;
    op    = 6'b100000;
    #1;
    check_val("illegal_stall", {31'd0, stall}, 32'd0);
    tick();
    check_val("illegal_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
